// File: rtl/punchout_pkg.sv
// Shared types for the punch-out game blocks.
// Holds the attack-scheduler state encoding and the attack side encoding.
package punchout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WAIT    = 3'd2,
        ST_WINDUP  = 3'd3,
        ST_STRIKE  = 3'd4,
        ST_RECOVER = 3'd5
    } sched_state_e;

    localparam logic SIDE_LEFT  = 1'b0;
    localparam logic SIDE_RIGHT = 1'b1;

endpackage

// File: rtl/opponent_attack_scheduler_down_counter.sv
// Loadable down counter with a registered "count is one" flag.
// Ports: clk_i, rst_i (sync, active-high), load_i/load_val_i (load has
// priority), dec_i (decrement), is_one_o (count currently equals 1).
module down_counter #(
    parameter int unsigned W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         is_one_o
);

    logic [W-1:0] count_q;
    logic         is_one_q;

    // Flag is computed alongside the count so it is available as a flop output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q  <= '0;
            is_one_q <= 1'b0;
        end else if (load_i) begin
            count_q  <= load_val_i;
            is_one_q <= (load_val_i == W'(1));
        end else if (dec_i) begin
            count_q  <= count_q - W'(1);
            is_one_q <= (count_q == W'(2));
        end
    end

    assign is_one_o = is_one_q;

endmodule

// File: rtl/opponent_attack_scheduler.sv
// Opponent attack scheduler: draws random bits from the LFSR, waits a random
// delay, offers an attack over valid/ready, runs the strike window while
// watching the player's block input, and pulses hit or dodged.
// Ports: clock_i, reset_i (sync, active-high), enable_i (game running),
// rand_bit_i (LFSR bit), lfsr_enable_o (advance LFSR), attack_valid_o,
// attack_side_o, attack_ready_i (handshake), blocked_i (player block),
// hit_o / dodged_o (one-cycle result pulses), state_dbg_o (state encoding).
module opponent_attack_scheduler
    import punchout_pkg::*;
#(
    parameter int unsigned DELAY_BITS     = 4,
    parameter int unsigned BASE_DELAY     = 16,
    parameter int unsigned STRIKE_CYCLES  = 4,
    parameter int unsigned RECOVER_CYCLES = 6
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic       rand_bit_i,
    output logic       lfsr_enable_o,
    output logic       attack_valid_o,
    output logic       attack_side_o,
    input  logic       attack_ready_i,
    input  logic       blocked_i,
    output logic       hit_o,
    output logic       dodged_o,
    output logic [2:0] state_dbg_o
);

    localparam int unsigned WAIT_MAX = BASE_DELAY + (1 << DELAY_BITS) - 1;
    localparam int unsigned MAX_A    = (WAIT_MAX > STRIKE_CYCLES) ? WAIT_MAX : STRIKE_CYCLES;
    localparam int unsigned MAX_CNT  = (MAX_A > RECOVER_CYCLES) ? MAX_A : RECOVER_CYCLES;
    localparam int unsigned CNT_W    = $clog2(MAX_CNT + 1);
    localparam int unsigned BIT_W    = $clog2(DELAY_BITS + 1);

    sched_state_e            state_q;
    logic [DELAY_BITS-1:0]   sh_q;
    logic [DELAY_BITS:0]     sh_d;
    logic [BIT_W-1:0]        bit_cnt_q;
    logic                    side_q;
    logic                    blk_seen_q;
    logic                    lfsr_en_q;
    logic                    valid_q;
    logic                    hit_q;
    logic                    dodged_q;
    logic                    last_bit;

    logic                    cnt_load;
    logic                    cnt_dec;
    logic [CNT_W-1:0]        cnt_load_val;
    logic                    cnt_one;

    // sh_q keeps the bits gathered so far; the full word exists only as sh_d
    // on the last COLLECT cycle, where its MSB is the first collected bit.
    assign sh_d     = {sh_q, rand_bit_i};
    assign last_bit = (bit_cnt_q == BIT_W'(DELAY_BITS));

    // One shared counter times WAIT, STRIKE and RECOVER in turn.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = '0;
        case (state_q)
            ST_COLLECT: begin
                if (last_bit) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(BASE_DELAY) + CNT_W'(sh_d[DELAY_BITS-1:0]);
                end
            end
            ST_WAIT:    cnt_dec = 1'b1;
            ST_WINDUP: begin
                if (attack_ready_i) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(STRIKE_CYCLES);
                end
            end
            ST_STRIKE: begin
                if (cnt_one) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(RECOVER_CYCLES);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RECOVER: cnt_dec = 1'b1;
            default: ;
        endcase
    end

    down_counter #(.W(CNT_W)) u_timer (
        .clk_i      (clock_i),
        .rst_i      (reset_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .is_one_o   (cnt_one)
    );

    // Attack FSM; output flops are set on the transition into the state
    // that owns them, so they default low every cycle.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            sh_q       <= '0;
            bit_cnt_q  <= '0;
            side_q     <= SIDE_LEFT;
            blk_seen_q <= 1'b0;
            lfsr_en_q  <= 1'b0;
            valid_q    <= 1'b0;
            hit_q      <= 1'b0;
            dodged_q   <= 1'b0;
        end else begin
            lfsr_en_q <= 1'b0;
            valid_q   <= 1'b0;
            hit_q     <= 1'b0;
            dodged_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable_i) begin
                        state_q   <= ST_COLLECT;
                        bit_cnt_q <= '0;
                        lfsr_en_q <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    sh_q <= sh_d[DELAY_BITS-1:0];
                    if (!enable_i) begin
                        state_q <= ST_IDLE;
                    end else if (last_bit) begin
                        side_q  <= sh_d[DELAY_BITS];
                        state_q <= ST_WAIT;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        lfsr_en_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!enable_i) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_one) begin
                        state_q <= ST_WINDUP;
                        valid_q <= 1'b1;
                    end
                end
                ST_WINDUP: begin
                    // Disabling the game is the only way to withdraw an offer.
                    if (!enable_i) begin
                        state_q <= ST_IDLE;
                    end else if (attack_ready_i) begin
                        state_q    <= ST_STRIKE;
                        blk_seen_q <= 1'b0;
                    end else begin
                        valid_q <= 1'b1;
                    end
                end
                ST_STRIKE: begin
                    if (cnt_one) begin
                        state_q  <= ST_RECOVER;
                        dodged_q <= blk_seen_q | blocked_i;
                        hit_q    <= ~(blk_seen_q | blocked_i);
                    end else begin
                        blk_seen_q <= blk_seen_q | blocked_i;
                    end
                end
                ST_RECOVER: begin
                    if (cnt_one) begin
                        if (enable_i) begin
                            state_q   <= ST_COLLECT;
                            bit_cnt_q <= '0;
                            lfsr_en_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign lfsr_enable_o  = lfsr_en_q;
    assign attack_valid_o = valid_q;
    assign attack_side_o  = side_q;
    assign hit_o          = hit_q;
    assign dodged_o       = dodged_q;
    assign state_dbg_o    = 3'(state_q);

endmodule

// File: tb/tb_opponent_attack_scheduler.sv
// Directed bench for opponent_attack_scheduler with default parameters.
module tb_opponent_attack_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       rand_bit;
    logic       attack_ready;
    logic       blocked;
    logic       lfsr_enable;
    logic       attack_valid;
    logic       attack_side;
    logic       hit;
    logic       dodged;
    logic [2:0] state_dbg;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    opponent_attack_scheduler dut (
        .clock_i        (clk),
        .reset_i        (reset),
        .enable_i       (enable),
        .rand_bit_i     (rand_bit),
        .lfsr_enable_o  (lfsr_enable),
        .attack_valid_o (attack_valid),
        .attack_side_o  (attack_side),
        .attack_ready_i (attack_ready),
        .blocked_i      (blocked),
        .hit_o          (hit),
        .dodged_o       (dodged),
        .state_dbg_o    (state_dbg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Counts consecutive cycles spent in state st (bounded), and result pulses seen.
    task automatic count_state(input logic [2:0] st, output int n, output int pulses);
        n = 0;
        pulses = 0;
        while (state_dbg == st && n < 200) begin
            n++;
            if (hit || dodged) pulses++;
            tick();
        end
    endtask

    // Feeds five bits during COLLECT, bits[4] first; counts lfsr_enable cycles.
    task automatic collect(input logic [4:0] bits, output int lfsr_cycles);
        lfsr_cycles = 0;
        for (int k = 4; k >= 0; k--) begin
            if (lfsr_enable) lfsr_cycles++;
            rand_bit = bits[k];
            tick();
        end
        rand_bit = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p;
        int quiet;
        logic stable;

        reset = 1'b1; enable = 1'b0; rand_bit = 1'b0;
        attack_ready = 1'b0; blocked = 1'b0;
        tick();
        tick();
        chk("reset_state", 32'(state_dbg), 0);
        chk("reset_lfsr", 32'(lfsr_enable), 0);
        chk("reset_valid", 32'(attack_valid), 0);
        chk("reset_side", 32'(attack_side), 0);
        chk("reset_hit", 32'(hit), 0);
        chk("reset_dodged", 32'(dodged), 0);
        reset = 1'b0;
        tick();
        chk("idle_hold", 32'(state_dbg), 0);

        // Attack 1: bits 1,0,0,1,1 -> side right, WAIT 16+3
        enable = 1'b1;
        tick();
        chk("collect_entry", 32'(state_dbg), 1);
        collect(5'b10011, n);
        chk("lfsr_cycles_1", 32'(n), 5);
        chk("wait_entry", 32'(state_dbg), 2);
        chk("wait_lfsr_low", 32'(lfsr_enable), 0);
        count_state(3'd2, n, p);
        chk("wait_len_19", 32'(n), 19);
        chk("windup_state", 32'(state_dbg), 3);
        chk("windup_valid", 32'(attack_valid), 1);
        chk("windup_side", 32'(attack_side), 1);

        // Hold ready low 50 cycles: offer must stay put
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (!(attack_valid === 1'b1 && attack_side === 1'b1 && state_dbg === 3'd3)) stable = 1'b0;
            tick();
        end
        chk("windup_stable", 32'(stable), 1);

        // Accept with blocked high in the acceptance cycle (ignored)
        attack_ready = 1'b1; blocked = 1'b1;
        tick();
        attack_ready = 1'b0; blocked = 1'b0;
        chk("strike_entry", 32'(state_dbg), 4);
        chk("strike_valid_low", 32'(attack_valid), 0);
        tick();
        tick();
        blocked = 1'b1;
        tick();
        blocked = 1'b0;
        tick();
        chk("recover_entry", 32'(state_dbg), 5);
        chk("dodged_pulse", 32'(dodged), 1);
        chk("dodged_no_hit", 32'(hit), 0);
        blocked = 1'b1;
        tick();
        blocked = 1'b0;
        chk("dodged_single", 32'(dodged), 0);
        count_state(3'd5, n, p);
        chk("recover_rest_len", 32'(n), 5);
        chk("recover_no_extra_pulse", 32'(p), 0);
        chk("b2b_collect", 32'(state_dbg), 1);
        chk("b2b_lfsr", 32'(lfsr_enable), 1);

        // Attack 2: all-ones stream -> WAIT 31, no block -> hit
        collect(5'b11111, n);
        chk("lfsr_cycles_2", 32'(n), 5);
        count_state(3'd2, n, p);
        chk("wait_len_31", 32'(n), 31);
        chk("windup_side_2", 32'(attack_side), 1);
        attack_ready = 1'b1;
        tick();
        attack_ready = 1'b0;
        chk("strike_next_cycle", 32'(state_dbg), 4);
        count_state(3'd4, n, p);
        chk("strike_len", 32'(n), 4);
        chk("hit_pulse", 32'(hit), 1);
        chk("hit_no_dodge", 32'(dodged), 0);
        enable = 1'b0;
        tick();
        chk("hit_single", 32'(hit), 0);
        count_state(3'd5, n, p);
        chk("recover_rest_len_2", 32'(n), 5);
        chk("idle_after_recover", 32'(state_dbg), 0);

        // Attack 3: enable dropped in WAIT
        enable = 1'b1;
        tick();
        collect(5'b00000, n);
        chk("wait_entry_3", 32'(state_dbg), 2);
        tick();
        tick();
        tick();
        enable = 1'b0;
        tick();
        chk("wait_abort_idle", 32'(state_dbg), 0);
        chk("wait_abort_valid", 32'(attack_valid), 0);
        quiet = 0;
        for (int i = 0; i < 40; i++) begin
            if (hit || dodged || attack_valid || lfsr_enable || state_dbg != 3'd0) quiet++;
            tick();
        end
        chk("wait_abort_quiet", 32'(quiet), 0);

        // Attack 4: bits 0,0,0,0,1 -> side left, WAIT 17; enable dropped in STRIKE
        enable = 1'b1;
        tick();
        collect(5'b00001, n);
        count_state(3'd2, n, p);
        chk("wait_len_17", 32'(n), 17);
        chk("windup_valid_4", 32'(attack_valid), 1);
        chk("windup_side_left", 32'(attack_side), 0);
        attack_ready = 1'b1;
        tick();
        attack_ready = 1'b0;
        enable = 1'b0;
        chk("strike_entry_4", 32'(state_dbg), 4);
        count_state(3'd4, n, p);
        chk("strike_len_disabled", 32'(n), 4);
        chk("hit_after_disable", 32'(hit), 1);
        count_state(3'd5, n, p);
        chk("recover_len_disabled", 32'(n), 6);
        chk("recover_one_pulse", 32'(p), 1);
        chk("idle_after_disable", 32'(state_dbg), 0);

        // Attack 5: reset mid-handshake in WINDUP
        enable = 1'b1;
        tick();
        collect(5'b00000, n);
        count_state(3'd2, n, p);
        chk("wait_len_16", 32'(n), 16);
        chk("windup_valid_5", 32'(attack_valid), 1);
        reset = 1'b1;
        attack_ready = 1'b1;
        tick();
        chk("rst_windup_state", 32'(state_dbg), 0);
        chk("rst_windup_valid", 32'(attack_valid), 0);
        chk("rst_windup_hit", 32'(hit), 0);
        chk("rst_windup_dodged", 32'(dodged), 0);
        chk("rst_windup_lfsr", 32'(lfsr_enable), 0);
        reset = 1'b0;
        attack_ready = 1'b0;
        enable = 1'b0;
        tick();
        chk("rst_then_idle", 32'(state_dbg), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/opponent_attack_scheduler.md
# opponent_attack_scheduler

Consumes the pseudo-random bit stream produced by the game's LFSR and turns it into timed opponent punch events for the control path. Each attack cycle collects fresh random bits, waits a random delay, offers the attack to the game control over a valid/ready handshake, runs the strike window while sampling the player's block input, and reports hit or dodge. It sits between the LFSR (its bit source) and the game control/datapath (its consumer).

## Interface
- DELAY_BITS, 4: random delay field width; each attack collects DELAY_BITS+1 bits
- BASE_DELAY, 16: minimum WAIT length in cycles (≥1)
- STRIKE_CYCLES, 4: strike window length (≥1)
- RECOVER_CYCLES, 6: post-strike idle length (≥1)

- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- enable  in  1  game running; low parks the block in IDLE
- rand_bit  in  1  LFSR output bit, valid every cycle
- lfsr_enable  out  1  high exactly while bits are being consumed (advances the LFSR)
- attack_valid  out  1  attack offered to control
- attack_side  out  1  0 = left, 1 = right; stable while attack_valid
- attack_ready  in  1  control accepts attack
- blocked  in  1  player block level, sampled during STRIKE
- hit  out  1  one-cycle pulse: strike landed
- dodged  out  1  one-cycle pulse: strike blocked
- state_dbg  out  3  current state encoding

## Operation
- States: IDLE=0, COLLECT=1, WAIT=2, WINDUP=3, STRIKE=4, RECOVER=5.
- IDLE: when enable=1, go to COLLECT, clearing the bit counter.
- COLLECT: lfsr_enable=1, shift register sh <= {sh[DELAY_BITS-1:0], rand_bit} each cycle for exactly DELAY_BITS+1 cycles. On the last cycle, latch side=sh[DELAY_BITS] (first collected bit) and load wait counter = BASE_DELAY + sh[DELAY_BITS-1:0], computed at DELAY_BITS+1 bits plus BASE_DELAY width with no overflow. Then go to WAIT.
- WAIT: decrement each cycle, leaving after the count reaches 1. WAIT lasts BASE_DELAY+delay cycles.
- WINDUP: attack_valid=1, attack_side=side. The transfer occurs on the cycle with attack_valid & attack_ready, then go to STRIKE. Valid holds indefinitely until ready. The only permitted retraction is enable=0.
- STRIKE: STRIKE_CYCLES cycles. blk_seen is set if blocked=1 in any STRIKE cycle. Then go to RECOVER.
- RECOVER: in its first cycle, pulse dodged if blk_seen, else pulse hit (never both). After RECOVER_CYCLES cycles, go to COLLECT if enable=1, else IDLE.
- enable=0 in COLLECT, WAIT or WINDUP: go to IDLE next cycle, dropping lfsr_enable and attack_valid. In STRIKE or RECOVER: finish the attack and report, then go to IDLE.
- Reset: state IDLE. lfsr_enable, attack_valid, attack_side, hit, dodged = 0. state_dbg=0. sh, counters and blk_seen = 0.

## Timing
- All outputs are registered or decoded from the registered state. There is no combinational path from attack_ready/blocked to outputs.
- enable rise at cycle t puts the block in COLLECT at t+1. lfsr_enable is high for cycles t+1 … t+DELAY_BITS+1.
- attack_valid first rises BASE_DELAY+delay cycles after COLLECT ends.
- If ready is high in the first WINDUP cycle, STRIKE begins the next cycle.
- The hit/dodged pulse occurs in the cycle after the last STRIKE cycle.
- blocked asserted in the WINDUP acceptance cycle or in the first RECOVER cycle is ignored.
- reset has priority over every input in every state, including mid-handshake.

## Structure
- Shared package `punchout_pkg`: state enum/localparams, side encoding (SIDE_LEFT/SIDE_RIGHT).
- One sub-module is natural: `down_counter` (load, decrement, is_one flag). It is reused for WAIT, STRIKE and RECOVER timing.
- The FSM, shift register and blk_seen live in the top module.

## Test plan
- Reset while in WINDUP with valid high → next cycle attack_valid=0, state_dbg=0, hit=dodged=0.
- rand_bit sequence 1,0,0,1,1 with defaults → lfsr_enable high 5 cycles, side=1, WAIT lasts 16+3=19 cycles, then attack_valid=1 with attack_side=1.
- attack_ready held low 50 cycles in WINDUP → attack_valid and attack_side stable throughout. Ready pulse → STRIKE next cycle.
- blocked=1 only in the 3rd STRIKE cycle → dodged single pulse, hit=0. blocked=0 throughout → hit single pulse.
- enable dropped in WAIT → IDLE next cycle, no pulses. enable dropped in STRIKE → attack completes, hit/dodged reported, then IDLE after RECOVER.
- All-ones bit stream (DELAY_BITS=4) → WAIT = 31 cycles, no counter wrap. Back-to-back attacks with enable held → COLLECT follows RECOVER immediately.
